dmem_access_ctrl: RTL
=====================

// Module: dmem_access_ctrl
// PURPOSE
//  Consumer end of the EX/MEM pipeline register. Takes the latched memory-control bits, address and store data.
//  Runs a request/acknowledge transaction with a multi-cycle data memory.
//  Drives halt_o back to the pipeline registers, which hold while halt_i is high, until the access completes.
//  Returns registered load data to the MEM/WB register.
// PARAMETERS
//  ADDR_W   32   address width
//  DATA_W   32   data width
//  TIMEOUT  255  max BUSY cycles without ack; used only when DMEM_TIMEOUT_EN is defined
// PORTS
//  clk_i       in   1       clock
//  rst_i       in   1       asynchronous, active-low reset
//  M_i         in   2       [1]=MemRead, [0]=MemWrite (from EX/MEM M_o)
//  addr_i      in   ADDR_W  access address (from EX/MEM addr_o)
//  data_i      in   DATA_W  store data (from EX/MEM data_o)
//  halt_o      out  1       stall request to all pipeline registers
//  mem_en_o    out  1       memory request valid
//  mem_we_o    out  1       1=write, 0=read
//  mem_addr_o  out  ADDR_W  memory address
//  mem_data_o  out  DATA_W  memory write data
//  mem_ack_i   in   1       memory completion strobe, one cycle
//  mem_data_i  in   DATA_W  memory read data, valid with mem_ack_i
//  rdata_o     out  DATA_W  registered load result
//  err_o       out  1       sticky timeout flag
// BEHAVIOUR
//  Reset: state IDLE; mem_en_o, mem_we_o, err_o = 0; mem_addr_o, mem_data_o, rdata_o = 0.
//   - Reset mid-transaction aborts immediately. mem_en_o drops asynchronously.
//  req = M_i[1] | M_i[0]. M_i = 2'b11 is treated as a write.
//  FSM states: IDLE, BUSY, DONE.
//  IDLE:
//   - req = 0: stay in IDLE; halt_o = 0.
//   - req = 1: halt_o = 1, combinational in the same cycle.
//   - On the edge: register addr_i, data_i and M_i[0] into mem_addr_o, mem_data_o and mem_we_o.
//   - Set mem_en_o = 1 and go to BUSY.
//  BUSY:
//   - halt_o = 1; mem_* outputs held stable.
//   - On a cycle with mem_ack_i = 1: mem_en_o <= 0; go to DONE.
//   - If the access is a read, rdata_o <= mem_data_i on that edge. Writes leave rdata_o unchanged.
//  DONE:
//   - halt_o = 0 for exactly one cycle, so the pipeline advances once.
//   - Always go to IDLE; the new EX/MEM contents are sampled there.
//   - This prevents re-issuing the same access.
//  Latency:
//   - Ack in the first BUSY cycle gives halt_o high for 2 cycles and completion in 3.
//   - Each extra BUSY cycle adds one stall cycle.
//  mem_ack_i in IDLE or DONE: ignored, no state or data change.
//  Back-to-back accesses: a new access can start no sooner than the cycle after DONE.
//  rdata_o holds its value until the next completed read.
// CONFIGURATION
//  DMEM_TIMEOUT_EN defined:
//   - An 8-bit-min counter clears on IDLE->BUSY and increments each BUSY cycle without ack.
//   - When count == TIMEOUT: mem_en_o <= 0, err_o <= 1 (sticky until reset), rdata_o <= 0 on a read, go to DONE.
//   - If ack arrives on the same cycle as the limit, ack wins and err_o is unchanged.
//  DMEM_TIMEOUT_EN undefined:
//   - No counter; BUSY waits indefinitely.
//   - err_o is tied to 0.
// TESTING
//  1. Read, immediate ack:
//   - Stimulus: M_i=2'b10, addr=0x40; ack on the first BUSY cycle with mem_data_i=0xDEADBEEF.
//   - Required: halt_o high 2 cycles; mem_en_o/mem_we_o = 1/0 for 1 cycle; rdata_o=0xDEADBEEF; halt_o=0 in DONE.
//  2. Write, ack after 4 cycles:
//   - Stimulus: M_i=2'b01, addr=0x10, data=0x12345678.
//   - Required: mem_we_o=1; mem_addr_o/mem_data_o stable for 4 cycles; halt_o high 5 cycles; rdata_o unchanged.
//  3. Back-to-back:
//   - Stimulus: read 0x0, then write 0x4 on consecutive instructions.
//   - Required: exactly one halt_o-low cycle between the two transactions; each address issued exactly once.
//  4. Stray ack and no-op:
//   - Stimulus: M_i=0 with mem_ack_i pulsed.
//   - Required: halt_o=0, mem_en_o=0, rdata_o unchanged.
//  5. Reset mid-access:
//   - Stimulus: rst_i low during BUSY.
//   - Required: mem_en_o=0 and halt_o=0 immediately; state IDLE after release; a new request is issued normally.
//  6. Timeout, DMEM_TIMEOUT_EN with TIMEOUT=8:
//   - Stimulus: read with no ack.
//   - Required: after 8 BUSY cycles err_o=1, rdata_o=0, DONE reached.
//   - Undefined build: still BUSY, err_o=0.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: request/ack handshake with a multi-cycle memory, pipeline halt and registered load data.
// Optional busy timeout with a sticky error flag is built when DMEM_TIMEOUT_EN is defined.
module dmem_access_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [1:0]        M_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              halt_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_data_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              err_o
);

   // state | meaning
   // IDLE  | waiting for a request from EX/MEM
   // BUSY  | request on the bus, waiting for ack
   // DONE  | one-cycle release so the pipeline advances exactly once
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t              state_q, state_d;
   logic                en_q, en_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                req;

`ifdef DMEM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
`endif

   assign req = M_i[1] | M_i[0];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         en_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
`ifdef DMEM_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
`ifdef DMEM_TIMEOUT_EN
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      en_d    = en_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
`ifdef DMEM_TIMEOUT_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (req) begin
               addr_d  = addr_i;
               wdata_d = data_i;
               we_d    = M_i[0];
               en_d    = 1'b1;
               state_d = BUSY;
`ifdef DMEM_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         BUSY: begin
            if (mem_ack_i) begin
               en_d    = 1'b0;
               state_d = DONE;
               if (!we_q) rdata_d = mem_data_i;
            end
`ifdef DMEM_TIMEOUT_EN
            // Ack on the limit cycle takes priority over the timeout.
            else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               en_d    = 1'b0;
               err_d   = 1'b1;
               state_d = DONE;
               if (!we_q) rdata_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Gated by reset so a stall request drops immediately when the access is aborted.
   assign halt_o     = rst_i & (((state_q == IDLE) & req) | (state_q == BUSY));
   assign mem_en_o   = en_q;
   assign mem_we_o   = we_q;
   assign mem_addr_o = addr_q;
   assign mem_data_o = wdata_q;
   assign rdata_o    = rdata_q;
`ifdef DMEM_TIMEOUT_EN
   assign err_o      = err_q;
`else
   assign err_o      = 1'b0;
`endif

endmodule
